// File: rtl/ladybird_rr_bus_arbiter.sv
// ladybird_rr_bus_arbiter
// Shares one slave port among N_INPUT requesters. A round-robin pointer sets
// priority. Selection is combinational, so a grant shows up in the same cycle
// as the request. Each accepted read puts the winner's index into an owner
// FIFO. The FIFO sends every in-order read response back to the requester that
// issued that read.
//
// Ports
//   clk, anrst      clock, asynchronous active-low reset
//   in_req/in_gnt   per-requester request / grant (grant follows out_gnt)
//   in_addr/in_wstrb/in_wdata  packed per-requester payloads, slice i = requester i
//   in_rdata        read data broadcast to all requesters (passthrough)
//   in_data_gnt     per-requester read-response strobe
//   out_req/out_gnt slave-side handshake
//   out_addr/out_wstrb/out_wdata  winner's payload (zero when idle)
//   out_rdata/out_data_gnt        slave read response
//   err             sticky: a response arrived with no read outstanding
module ladybird_rr_bus_arbiter #(
   parameter int unsigned N_INPUT         = 2,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                          clk,
   input  logic                          anrst,
   input  logic [N_INPUT-1:0]            in_req,
   output logic [N_INPUT-1:0]            in_gnt,
   input  logic [N_INPUT*ADDR_W-1:0]     in_addr,
   input  logic [N_INPUT*(DATA_W/8)-1:0] in_wstrb,
   input  logic [N_INPUT*DATA_W-1:0]     in_wdata,
   output logic [DATA_W-1:0]             in_rdata,
   output logic [N_INPUT-1:0]            in_data_gnt,
   output logic                          out_req,
   input  logic                          out_gnt,
   output logic [ADDR_W-1:0]             out_addr,
   output logic [DATA_W/8-1:0]           out_wstrb,
   output logic [DATA_W-1:0]             out_wdata,
   input  logic [DATA_W-1:0]             out_rdata,
   input  logic                          out_data_gnt,
   output logic                          err
);

   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned IDX_W   = $clog2(N_INPUT);
   localparam int unsigned FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   winner;
   logic               winner_read;
   logic [N_INPUT-1:0] is_read;
   logic [N_INPUT-1:0] eligible;
   logic               found_hi;
   logic               found_lo;
   logic               accept;
   logic               push;
   logic               pop;

   logic [IDX_W-1:0]   owner_mem [MAX_OUTSTANDING];
   logic [FIFO_AW-1:0] head_q;
   logic [FIFO_AW-1:0] tail_q;
   logic [CNT_W-1:0]   count_q;
   logic               fifo_full;
   logic               fifo_empty;
   logic [IDX_W-1:0]   head_owner;

   // The full test uses the registered count only. A pop in the same cycle
   // does not free a slot until the next cycle.
   assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign head_owner = owner_mem[head_q];

   // Decode each requester as read or write. Block reads while the FIFO is full.
   always_comb begin
      is_read  = '0;
      eligible = '0;
      for (int i = 0; i < int'(N_INPUT); i++) begin
         is_read[i]  = (in_wstrb[i*STRB_W +: STRB_W] == '0);
         eligible[i] = in_req[i] & ~(is_read[i] & fifo_full);
      end
   end

   // Pick the first eligible index at or above ptr. If none, wrap to the lowest eligible index.
   always_comb begin
      winner   = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int i = 0; i < int'(N_INPUT); i++) begin
         if (!found_hi && eligible[i] && (IDX_W'(i) >= ptr_q)) begin
            winner   = IDX_W'(i);
            found_hi = 1'b1;
         end
      end
      for (int i = 0; i < int'(N_INPUT); i++) begin
         if (!found_hi && !found_lo && eligible[i]) begin
            winner   = IDX_W'(i);
            found_lo = 1'b1;
         end
      end
   end

   assign out_req = |eligible;
   assign accept  = out_req & out_gnt;
   assign push    = accept & winner_read;
   assign pop     = out_data_gnt & ~fifo_empty;

   // Forward the winner's payload and route out_gnt back to the winner only.
   always_comb begin
      out_addr    = '0;
      out_wstrb   = '0;
      out_wdata   = '0;
      in_gnt      = '0;
      winner_read = 1'b0;
      for (int i = 0; i < int'(N_INPUT); i++) begin
         if (out_req && (winner == IDX_W'(i))) begin
            out_addr    = in_addr[i*ADDR_W +: ADDR_W];
            out_wstrb   = in_wstrb[i*STRB_W +: STRB_W];
            out_wdata   = in_wdata[i*DATA_W +: DATA_W];
            in_gnt[i]   = out_gnt;
            winner_read = is_read[i];
         end
      end
   end

   // Send the response strobe to the owner at the FIFO head. Read data is passed through unchanged.
   always_comb begin
      in_data_gnt = '0;
      for (int i = 0; i < int'(N_INPUT); i++) begin
         in_data_gnt[i] = pop && (head_owner == IDX_W'(i));
      end
   end

   assign in_rdata = out_rdata;

   // Round-robin pointer. It moves past the winner only when a transfer is accepted.
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (winner == IDX_W'(N_INPUT - 1)) ? '0 : winner + IDX_W'(1);
      end
   end

   // Owner FIFO storage. Entries are only read when count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         owner_mem[tail_q] <= winner;
      end
   end

   // Owner FIFO pointers and occupancy count.
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= (tail_q == FIFO_AW'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + FIFO_AW'(1);
         end
         if (pop) begin
            head_q <= (head_q == FIFO_AW'(MAX_OUTSTANDING - 1)) ? '0 : head_q + FIFO_AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky flag for a response that arrives with no read outstanding.
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         err <= 1'b0;
      end else if (out_data_gnt && fifo_empty) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ladybird_rr_bus_arbiter.sv
module tb_ladybird_rr_bus_arbiter;

   logic        clk;
   logic        anrst;
   logic [1:0]  in_req;
   logic [1:0]  in_gnt;
   logic [63:0] in_addr;
   logic [7:0]  in_wstrb;
   logic [63:0] in_wdata;
   logic [31:0] in_rdata;
   logic [1:0]  in_data_gnt;
   logic        out_req;
   logic        out_gnt;
   logic [31:0] out_addr;
   logic [3:0]  out_wstrb;
   logic [31:0] out_wdata;
   logic [31:0] out_rdata;
   logic        out_data_gnt;
   logic        err;

   int checks;
   int errors;
   int owners[$];   // expected read owners, in slave response order

   ladybird_rr_bus_arbiter #(
      .N_INPUT(2), .DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk), .anrst(anrst),
      .in_req(in_req), .in_gnt(in_gnt),
      .in_addr(in_addr), .in_wstrb(in_wstrb), .in_wdata(in_wdata),
      .in_rdata(in_rdata), .in_data_gnt(in_data_gnt),
      .out_req(out_req), .out_gnt(out_gnt),
      .out_addr(out_addr), .out_wstrb(out_wstrb), .out_wdata(out_wdata),
      .out_rdata(out_rdata), .out_data_gnt(out_data_gnt),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after posedge; outputs are sampled 4 units later.
   task automatic settle();
      #4;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rq(input int i, input logic r, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
      in_req[i]          = r;
      in_addr[i*32 +: 32] = a;
      in_wstrb[i*4 +: 4]  = s;
      in_wdata[i*32 +: 32] = d;
   endtask

   // Drive one slave response and check it against the scoreboard head.
   task automatic respond(input string tag, input logic [31:0] d);
      int o;
      out_data_gnt = 1'b1;
      out_rdata    = d;
      settle();
      o = (owners.size() > 0) ? owners.pop_front() : -1;
      chk({tag, "_dgnt"}, 32'(in_data_gnt), (o < 0) ? 32'h0 : (32'h1 << o));
      chk({tag, "_rdata"}, in_rdata, d);
      advance();
      out_data_gnt = 1'b0;
   endtask

   logic [1:0]  exp_gnt  [4];
   logic [31:0] exp_addr [4];

   initial begin
      int o;
      checks = 0;
      errors = 0;
      anrst = 1'b0;
      in_req = '0; in_addr = '0; in_wstrb = '0; in_wdata = '0;
      out_gnt = 1'b0; out_rdata = '0; out_data_gnt = 1'b0;
      #1;

      // Outputs during reset: arbitration stays combinational, ptr is held at 0
      set_rq(0, 1'b1, 32'h100, 4'hF, 32'h1111);
      set_rq(1, 1'b1, 32'h200, 4'hF, 32'h2222);
      settle();
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_out_req", 32'(out_req), 32'h1);
      chk("rst_gnt_idle", 32'(in_gnt), 32'h0);
      chk("rst_out_addr", out_addr, 32'h100);
      chk("rst_dgnt", 32'(in_data_gnt), 32'h0);
      advance();
      out_gnt = 1'b1;
      settle();
      chk("rst_gnt", 32'(in_gnt), 32'h1);
      advance();
      settle();
      chk("rst_ptr_held", 32'(in_gnt), 32'h1);
      advance();
      anrst = 1'b1;

      // Both requesters write continuously, so grants alternate 0,1,0,1
      exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
      for (int k = 0; k < 4; k++) begin
         settle();
         chk($sformatf("alt_gnt%0d", k), 32'(in_gnt), 32'(exp_gnt[k]));
         chk($sformatf("alt_addr%0d", k), out_addr, exp_addr[k]);
         advance();
      end

      // A stalled read from requester 0 keeps winning; requester 1 waits
      set_rq(0, 1'b1, 32'h110, 4'h0, 32'h0);
      out_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("stall_gnt%0d", k), 32'(in_gnt), 32'h0);
         chk($sformatf("stall_addr%0d", k), out_addr, 32'h110);
         advance();
      end
      out_gnt = 1'b1;
      settle();
      chk("stall_accept", 32'(in_gnt), 32'h1);
      owners.push_back(0);
      advance();
      // ptr has moved to 1 after the accept, so requester 1's read wins
      set_rq(0, 1'b1, 32'h120, 4'hF, 32'h3333);
      set_rq(1, 1'b1, 32'h210, 4'h0, 32'h0);
      settle();
      chk("ptr_moved", 32'(in_gnt), 32'h2);
      owners.push_back(1);
      advance();
      in_req = '0;
      settle();
      chk("idle_out_req", 32'(out_req), 32'h0);
      chk("idle_out_addr", out_addr, 32'h0);
      respond("r01_a", 32'hA0);
      respond("r01_b", 32'hB0);

      // Reads from 1, 0, 1 come back in order with matching data
      set_rq(1, 1'b1, 32'h220, 4'h0, 32'h0);
      settle();
      chk("r101_g0", 32'(in_gnt), 32'h2);
      owners.push_back(1);
      advance();
      in_req = '0;
      set_rq(0, 1'b1, 32'h130, 4'h0, 32'h0);
      settle();
      chk("r101_g1", 32'(in_gnt), 32'h1);
      owners.push_back(0);
      advance();
      in_req = '0;
      set_rq(1, 1'b1, 32'h230, 4'h0, 32'h0);
      settle();
      chk("r101_g2", 32'(in_gnt), 32'h2);
      owners.push_back(1);
      advance();
      in_req = '0;
      respond("r101_a", 32'hA);
      respond("r101_b", 32'hB);
      respond("r101_c", 32'hC);

      // Fill the FIFO with 4 reads from requester 0
      set_rq(0, 1'b1, 32'h300, 4'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         settle();
         chk($sformatf("fill_gnt%0d", k), 32'(in_gnt), 32'h1);
         owners.push_back(0);
         advance();
      end
      // With the FIFO full, the read is blocked but the write from requester 1 is granted
      set_rq(1, 1'b1, 32'h400, 4'hF, 32'h55);
      settle();
      chk("full_write_gnt", 32'(in_gnt), 32'h2);
      chk("full_write_strb", 32'(out_wstrb), 32'hF);
      advance();
      in_req[1] = 1'b0;
      // A pop in the same cycle does not unblock the read yet
      out_data_gnt = 1'b1;
      out_rdata = 32'hD0;
      settle();
      chk("full_pop_noreq", 32'(out_req), 32'h0);
      chk("full_pop_gnt", 32'(in_gnt), 32'h0);
      o = owners.pop_front();
      chk("full_pop_dgnt", 32'(in_data_gnt), 32'h1 << o);
      advance();
      out_data_gnt = 1'b0;
      settle();
      chk("unblock_next", 32'(in_gnt), 32'h1);
      owners.push_back(0);
      advance();
      in_req = '0;
      respond("full_pop2", 32'hD1);
      // A push and a pop in the same cycle leave the count unchanged
      in_req[0] = 1'b1;
      out_data_gnt = 1'b1;
      out_rdata = 32'hD2;
      settle();
      chk("pp_gnt", 32'(in_gnt), 32'h1);
      o = owners.pop_front();
      chk("pp_dgnt", 32'(in_data_gnt), 32'h1 << o);
      owners.push_back(0);
      advance();
      out_data_gnt = 1'b0;
      in_req = '0;
      while (owners.size() > 0) respond("drain", 32'hE0 + 32'(owners.size()));

      // A response with the FIFO empty is ignored and sets sticky err
      out_data_gnt = 1'b1;
      out_rdata = 32'hEE;
      settle();
      chk("spur_dgnt", 32'(in_data_gnt), 32'h0);
      chk("spur_rdata", in_rdata, 32'hEE);
      chk("spur_err_pre", 32'(err), 32'h0);
      advance();
      out_data_gnt = 1'b0;
      settle();
      chk("spur_err", 32'(err), 32'h1);
      advance();
      settle();
      chk("err_sticky", 32'(err), 32'h1);
      anrst = 1'b0;
      #1;
      chk("err_cleared", 32'(err), 32'h0);
      advance();
      anrst = 1'b1;

      // Reset with 2 reads outstanding discards them and clears ptr
      set_rq(1, 1'b1, 32'h240, 4'h0, 32'h0);
      settle();
      chk("rr_g1", 32'(in_gnt), 32'h2);
      advance();
      in_req = '0;
      set_rq(0, 1'b1, 32'h140, 4'h0, 32'h0);
      settle();
      chk("rr_g0", 32'(in_gnt), 32'h1);
      advance();
      in_req = '0;
      anrst = 1'b0;
      owners.delete();
      advance();
      anrst = 1'b1;
      set_rq(0, 1'b1, 32'h150, 4'hF, 32'h1);
      set_rq(1, 1'b1, 32'h250, 4'hF, 32'h2);
      settle();
      chk("post_rst_ptr0", 32'(in_gnt), 32'h1);
      advance();
      in_req = '0;
      out_gnt = 1'b0;
      out_data_gnt = 1'b1;
      settle();
      chk("post_rst_dgnt", 32'(in_data_gnt), 32'h0);
      advance();
      out_data_gnt = 1'b0;
      settle();
      chk("post_rst_err", 32'(err), 32'h1);
      advance();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ladybird_rr_bus_arbiter.md
LADYBIRD_RR_BUS_ARBITER -- requirements
Module: ladybird_rr_bus_arbiter

Interface
REQ-001 Parameters SHALL be: N_INPUT, default 2, number of requesters (2..8); DATA_W, default 32, data width; ADDR_W, default 32, address width; MAX_OUTSTANDING, default 4, read-owner FIFO depth (power of 2).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge
- anrst  in  1  asynchronous active-low reset
- in_req  in  N_INPUT  per-requester request
- in_gnt  out  N_INPUT  per-requester grant
- in_addr  in  N_INPUT*ADDR_W  packed addresses, requester i at slice i
- in_wstrb  in  N_INPUT*(DATA_W/8)  packed byte strobes
- in_wdata  in  N_INPUT*DATA_W  packed write data
- in_rdata  out  DATA_W  read data broadcast to all requesters
- in_data_gnt  out  N_INPUT  per-requester read-response strobe
- out_req  out  1  request to shared slave
- out_gnt  in  1  slave accepts
- out_addr  out  ADDR_W  forwarded address
- out_wstrb  out  DATA_W/8  forwarded strobes
- out_wdata  out  DATA_W  forwarded write data
- out_rdata  in  DATA_W  slave read data
- out_data_gnt  in  1  slave read-response strobe
- err  out  1  sticky protocol-error flag
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-004 Transfer accepted in the cycle where req and gnt are both high at rising clk edge; wstrb != 0 denotes write (no response), wstrb == 0 denotes read (exactly one later out_data_gnt, in order).
REQ-005 Eligible set = in_req[i], excluding requesters presenting a read while owner FIFO is full.
REQ-006 Winner SHALL be first eligible index at or after round-robin pointer ptr, wrapping N_INPUT-1 -> 0; selection combinational, zero-cycle latency.
REQ-007 out_req SHALL be high iff eligible set non-empty; out_addr/out_wstrb/out_wdata SHALL be winner's slices; zero when out_req low.
REQ-008 in_gnt[winner] SHALL equal out_gnt; all other in_gnt bits SHALL be 0.
REQ-009 On accepted transfer, ptr SHALL become (winner+1) mod N_INPUT; otherwise ptr holds.
REQ-010 Requester SHALL keep winning until out_gnt (no preemption while out_gnt low); ptr does not move on stalled cycles.
REQ-011 On accepted read, winner index SHALL be pushed to owner FIFO.
REQ-012 On out_data_gnt with FIFO non-empty: in_data_gnt[head]=1 same cycle, in_rdata=out_rdata, head popped.
REQ-013 in_rdata SHALL pass out_rdata combinationally at all times; in_data_gnt all-zero when out_data_gnt low.
REQ-014 Push and pop in same cycle SHALL both occur; count unchanged.
REQ-015 Full check uses registered count before same-cycle pop (no bypass): at count==MAX_OUTSTANDING reads blocked even if pop coincides.
REQ-016 out_data_gnt with FIFO empty SHALL be ignored (no in_data_gnt) and set err=1; err cleared only by reset.
REQ-017 Response may arrive earliest cycle after its acceptance; same-cycle request/response for same read not supported.
REQ-018 FIFO pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-019 While anrst low: ptr=0, FIFO empty (count 0), err=0; outputs follow combinational rules above with FIFO empty.
REQ-020 Reset asserted mid-transaction SHALL discard all outstanding owners; post-reset responses flagged per REQ-016.
REQ-021 Deassertion of anrst is assumed synchronised externally; first arbitration on first clk edge after release.

Verification
REQ-022 Reset release, in_req=2'b11, out_gnt=1 continuous writes -> grants alternate 0,1,0,1; ptr sequence 1,0,1,0.
REQ-023 in_req[0] read, out_gnt=0 for 3 cycles then 1 -> in_gnt[0] high only on 4th cycle, in_req[1] never granted meanwhile, ptr 0->1 after acceptance.
REQ-024 Reads from requester 1,0,1 accepted, slave returns 3 responses (out_rdata 0xA,0xB,0xC) -> in_data_gnt pulses to 1,0,1 with matching data.
REQ-025 4 reads outstanding (MAX_OUTSTANDING=4), 5th read and a write pending -> write granted, read blocked; after one out_data_gnt read granted following cycle, not same cycle.
REQ-026 out_data_gnt with empty FIFO -> no in_data_gnt, err=1 and stays 1; anrst pulse -> err=0.
REQ-027 anrst asserted with 2 reads outstanding -> count=0, ptr=0; subsequent out_data_gnt sets err.
